// File: rtl/pipe_mem_stage.sv
// MEM stage: runs word loads/stores on a req/ack data bus,
// stalls upstream until the access completes, feeds MEM/WB.
module pipe_mem_stage #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wreg,
  input  logic        i_m2reg,
  input  logic        i_wmem,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_rn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] mmo,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        mem_err
);

  localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);
  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   rdata_q;
  logic [CW-1:0] cnt;
  logic          tmo_q;

  logic acc;
  logic mis;

  assign acc = i_m2reg | i_wmem;
  assign mis = acc & (i_alu[1:0] != 2'b00);

  assign mm2reg = i_m2reg;
  assign malu   = i_alu;
  assign mrn    = i_rn;

  // access sequencer: latch request, wait for ack or timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
      tmo_q      <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          tmo_q <= 1'b0;
          if (mis) begin
            mem_err <= 1'b1;
          end else if (acc) begin
            dmem_addr  <= i_alu;
            dmem_wdata <= i_b;
            dmem_we    <= i_wmem;
            dmem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (dmem_ack) begin
            if (!dmem_we)
              rdata_q <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (cnt == CNT_LAST) begin
            rdata_q  <= TMO_DATA;
            mem_err  <= 1'b1;
            tmo_q    <= 1'b1;
            dmem_req <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // stall and write-back view presented to MEM/WB
  always_comb begin
    mem_stall = 1'b0;
    mwreg     = 1'b0;
    mmo       = rdata_q;
    unique case (1'b1)
      (state == IDLE) && mis: begin
        mmo = '0;
      end
      (state == IDLE) && acc && !mis: begin
        mem_stall = 1'b1;
      end
      (state == IDLE) && !acc: begin
        mwreg = i_wreg;
      end
      (state == REQ): begin
        mem_stall = 1'b1;
      end
      (state == DONE): begin
        mwreg = i_wreg & ~tmo_q;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage (BUS_TIMEOUT=4).
// Each task drives one scenario and checks inline.
module tb_pipe_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_wreg, i_m2reg, i_wmem;
  logic [31:0] i_alu, i_b;
  logic [4:0]  i_rn;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall, mwreg, mm2reg;
  logic [31:0] mmo, malu;
  logic [4:0]  mrn;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_wreg(i_wreg), .i_m2reg(i_m2reg), .i_wmem(i_wmem),
    .i_alu(i_alu), .i_b(i_b), .i_rn(i_rn),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .mwreg(mwreg), .mm2reg(mm2reg),
    .mmo(mmo), .malu(malu), .mrn(mrn), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic w, input logic l, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rn);
    i_wreg = w; i_m2reg = l; i_wmem = s;
    i_alu = a; i_b = b; i_rn = rn;
  endtask

  task automatic set_nop();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Inputs already applied at posedge+1. Runs until the DONE cycle.
  task automatic do_access(input int ack_at, input logic [31:0] rd,
                           output int req_n, output int stall_n,
                           output logic [31:0] mmo_d, output logic mw_d,
                           output logic we_s, output logic [31:0] addr_s,
                           output logic [31:0] wd_s, output logic mw_bad,
                           output logic to);
    req_n = 0; stall_n = 0; mmo_d = 'x; mw_d = 1'bx;
    we_s = 1'bx; addr_s = 'x; wd_s = 'x; mw_bad = 1'b0; to = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!mem_stall && stall_n > 0) begin
        mmo_d = mmo; mw_d = mwreg; to = 1'b0;
        if (dmem_req) req_n = req_n + 100;
        break;
      end
      if (mem_stall) stall_n++;
      if (mem_stall && mwreg) mw_bad = 1'b1;
      if (dmem_req) begin
        req_n++;
        we_s = dmem_we; addr_s = dmem_addr; wd_s = dmem_wdata;
        if (req_n == ack_at) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
        end
      end
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      dmem_rdata = 32'h5555_AAAA;
    end
    if (to) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: stall never released, got stall_n=%0d need DONE", stall_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; set_nop(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    edge1(); edge1();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({dmem_req, mem_stall, mem_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b need 000", {dmem_req, mem_stall, mem_err});
    end
    n_cmp++;
    if (mmo !== 32'h0) begin
      n_bad++; $display("FAIL reset_mmo: got %h need 0", mmo);
    end
  endtask

  task automatic test_alu();
    edge1();
    set_in(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd7);
    #1;
    n_cmp++;
    if ({mem_stall, mwreg, dmem_req, mm2reg} !== 4'b0100) begin
      n_bad++;
      $display("FAIL alu_ctl: got %b need 0100", {mem_stall, mwreg, dmem_req, mm2reg});
    end
    n_cmp++;
    if (malu !== 32'h10 || mrn !== 5'd7) begin
      n_bad++; $display("FAIL alu_pass: got %h/%0d need 10/7", malu, mrn);
    end
    edge1();
    n_cmp++;
    if (dmem_req !== 1'b0) begin
      n_bad++; $display("FAIL alu_noreq: got %b need 0", dmem_req);
    end
    set_nop();
  endtask

  task automatic test_load();
    int rq, st; logic [31:0] md, ad, wd; logic mw, we, bad, to;
    edge1();
    set_in(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3);
    do_access(3, 32'hCAFE_F00D, rq, st, md, mw, we, ad, wd, bad, to);
    n_cmp++;
    if (rq !== 3 || st !== 4) begin
      n_bad++; $display("FAIL load_cycles: got req=%0d stall=%0d need 3/4", rq, st);
    end
    n_cmp++;
    if (md !== 32'hCAFE_F00D || mw !== 1'b1) begin
      n_bad++; $display("FAIL load_done: got %h/%b need cafef00d/1", md, mw);
    end
    n_cmp++;
    if (we !== 1'b0 || ad !== 32'h40 || bad !== 1'b0) begin
      n_bad++; $display("FAIL load_bus: got we=%b addr=%h mwbad=%b need 0/40/0", we, ad, bad);
    end
    edge1(); set_nop();
  endtask

  task automatic test_store();
    int rq, st; logic [31:0] md, ad, wd; logic mw, we, bad, to;
    edge1();
    set_in(1'b0, 1'b0, 1'b1, 32'h44, 32'h1234_5678, 5'd0);
    do_access(1, 32'h0BAD_0BAD, rq, st, md, mw, we, ad, wd, bad, to);
    n_cmp++;
    if (rq !== 1 || st !== 2) begin
      n_bad++; $display("FAIL store_cycles: got req=%0d stall=%0d need 1/2", rq, st);
    end
    n_cmp++;
    if (we !== 1'b1 || wd !== 32'h1234_5678 || ad !== 32'h44) begin
      n_bad++; $display("FAIL store_bus: got we=%b wd=%h ad=%h need 1/12345678/44", we, wd, ad);
    end
    n_cmp++;
    if (bad !== 1'b0 || md !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL store_wb: got mwbad=%b mmo=%h need 0/cafef00d", bad, md);
    end
    edge1(); set_nop();
  endtask

  task automatic test_both_is_store();
    int rq, st; logic [31:0] md, ad, wd; logic mw, we, bad, to;
    edge1();
    set_in(1'b1, 1'b1, 1'b1, 32'h4C, 32'hA5A5_0001, 5'd9);
    do_access(2, 32'h7777_7777, rq, st, md, mw, we, ad, wd, bad, to);
    n_cmp++;
    if (we !== 1'b1 || md !== 32'hCAFE_F00D || rq !== 2) begin
      n_bad++; $display("FAIL both_store: got we=%b mmo=%h req=%0d need 1/cafef00d/2", we, md, rq);
    end
    edge1(); set_nop();
  endtask

  task automatic test_back_to_back();
    int rq, st; logic [31:0] md, ad, wd; logic mw, we, bad, to;
    edge1();
    set_in(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd1);
    do_access(1, 32'h1111_0001, rq, st, md, mw, we, ad, wd, bad, to);
    n_cmp++;
    if (md !== 32'h1111_0001 || st !== 2) begin
      n_bad++; $display("FAIL b2b_first: got %h st=%0d need 11110001/2", md, st);
    end
    edge1();
    set_in(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 5'd2);
    do_access(2, 32'h2222_0002, rq, st, md, mw, we, ad, wd, bad, to);
    n_cmp++;
    if (md !== 32'h2222_0002 || ad !== 32'h84 || rq !== 2 || mw !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second: got %h ad=%h rq=%0d mw=%b need 22220002/84/2/1", md, ad, rq, mw);
    end
    edge1(); set_nop();
  endtask

  task automatic test_misaligned();
    edge1();
    set_in(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd4);
    #1;
    n_cmp++;
    if ({dmem_req, mem_stall, mwreg} !== 3'b000 || mmo !== 32'h0) begin
      n_bad++;
      $display("FAIL mis_pass: got %b mmo=%h need 000/0", {dmem_req, mem_stall, mwreg}, mmo);
    end
    edge1();
    n_cmp++;
    if (mem_err !== 1'b1 || dmem_req !== 1'b0) begin
      n_bad++; $display("FAIL mis_err: got err=%b req=%b need 1/0", mem_err, dmem_req);
    end
    set_nop();
    edge1(); edge1();
    n_cmp++;
    if (mem_err !== 1'b1) begin
      n_bad++; $display("FAIL mis_sticky: got %b need 1", mem_err);
    end
  endtask

  task automatic test_reset_mid();
    int rq; logic hit;
    edge1();
    set_in(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 5'd5);
    rq = 0; hit = 1'b0;
    for (int n = 0; n < 10 && !hit; n++) begin
      edge1();
      if (dmem_req) rq++;
      if (rq == 2) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++; $display("FAIL rmid_reach: got req=%0d need 2", rq);
    end
    reset = 1'b1;
    edge1();
    reset = 1'b0; set_nop();
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    #1;
    n_cmp++;
    if ({dmem_req, mem_stall, mem_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid_after: got %b need 000", {dmem_req, mem_stall, mem_err});
    end
    edge1();
    dmem_ack = 1'b0;
    #1;
    n_cmp++;
    if (mmo !== 32'h0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_ack_ign: got mmo=%h req=%b st=%b need 0/0/0", mmo, dmem_req, mem_stall);
    end
  endtask

  task automatic test_timeout();
    int rq, st; logic [31:0] md, ad, wd; logic mw, we, bad, to;
    edge1();
    set_in(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 5'd6);
    do_access(0, 32'h0, rq, st, md, mw, we, ad, wd, bad, to);
    n_cmp++;
    if (rq !== 4 || st !== 5) begin
      n_bad++; $display("FAIL tmo_cycles: got req=%0d stall=%0d need 4/5", rq, st);
    end
    n_cmp++;
    if (md !== 32'hDEAD_BEEF || mw !== 1'b0 || mem_err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_done: got %h mw=%b err=%b need deadbeef/0/1", md, mw, mem_err);
    end
    edge1(); set_nop();
    #1;
    n_cmp++;
    if (mwreg !== 1'b0 || mem_err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_after: got mw=%b err=%b need 0/1", mwreg, mem_err);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_both_is_store();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
